// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared state encoding, default sizes and index-width helper
package serial_add_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, ADD, DONE} state_t;
    localparam int DEF_WIDTH = 4;
    localparam int DEF_TICK_DIV = 3000000;
    function automatic int idx_w(input int w);
        return $clog2(w) + 1;
    endfunction
endpackage

// File: rtl/serial_add_tick.sv
// serial_add_tick: free-running divider producing a one-cycle advance tick while enabled
module serial_add_tick #(
    parameter int TICK_DIV = 4,
    parameter int CNT_W = 22
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);
    logic [CNT_W-1:0] cnt;
    // Counter rests at zero whenever disabled so a fresh enable always waits a full period
    always_ff @(posedge clk or negedge rst)
        if (!rst) cnt <= '0;
        else if (clr || !en) cnt <= '0;
        else cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    assign tick = en && !clr && cnt == LAST;
endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: sequences an LSB-first bit-serial add of two latched operands
module serial_add_ctrl import serial_add_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int TICK_DIV = DEF_TICK_DIV,
    parameter int CNT_W = 22
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [WIDTH-1:0]          a_in,
    input  logic [WIDTH-1:0]          b_in,
    input  logic                      start_pulse,
    input  logic                      step_pulse,
    input  logic                      clear_pulse,
    input  logic                      mode,
    output logic                      busy,
    output logic                      done,
    output logic [WIDTH:0]            sum_out,
    output logic [idx_w(WIDTH)-1:0]   bit_idx,
    output logic                      serial_bit
);
    localparam int IW = idx_w(WIDTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);
    state_t state, state_nxt;
    logic [WIDTH-1:0] a_reg, b_reg, sum_reg;
    logic carry_reg, tick, adv, s, c_nxt;
    serial_add_tick #(.TICK_DIV(TICK_DIV), .CNT_W(CNT_W)) u_tick (
        .clk(clk),
        .rst(rst),
        .en(state == ADD && !mode),
        .clr(state == LOAD || clear_pulse),
        .tick(tick)
    );
    always_comb begin
        adv = state == ADD && (mode ? step_pulse : tick);
        s = a_reg[0] ^ b_reg[0] ^ carry_reg;
        c_nxt = (a_reg[0] & b_reg[0]) | (carry_reg & (a_reg[0] ^ b_reg[0]));
        state_nxt = state;
        if (clear_pulse) state_nxt = IDLE;
        else if (state == IDLE || state == DONE) state_nxt = start_pulse ? LOAD : state;
        else if (state == LOAD) state_nxt = ADD;
        else state_nxt = (adv && bit_idx == LAST_IDX) ? DONE : ADD;
    end
    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else state <= state_nxt;
    always_ff @(posedge clk or negedge rst)
        if (!rst || clear_pulse) begin
            a_reg <= '0;
            b_reg <= '0;
            sum_reg <= '0;
            carry_reg <= 1'b0;
            bit_idx <= '0;
            serial_bit <= 1'b0;
        end else if (state == LOAD) begin
            a_reg <= a_in;
            b_reg <= b_in;
            sum_reg <= '0;
            carry_reg <= 1'b0;
            bit_idx <= '0;
            serial_bit <= 1'b0;
        end else if (adv) begin
            a_reg <= a_reg >> 1;
            b_reg <= b_reg >> 1;
            sum_reg <= {s, sum_reg[WIDTH-1:1]};
            carry_reg <= c_nxt;
            serial_bit <= s;
            bit_idx <= bit_idx + 1'b1;
        end
    assign busy = state == LOAD || state == ADD;
    assign done = state == DONE;
    assign sum_out = {carry_reg, sum_reg};
endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Sequencer for the 4-bit bit-serial adder datapath. It latches operands from the board switches on a debounced start key pulse. It then steps a full-adder cell with a carry flip-flop LSB-first, one bit per advance event, and presents the partial and final (WIDTH+1)-bit sum on LEDs. Advance events come either from an internal slow tick (auto mode) or from a debounced step key (single-step mode). It sits between the key debouncer outputs and the LED/segment display logic.

Parameters:
WIDTH, 4, operand width in bits
TICK_DIV, 3000000, clk cycles per auto-mode advance (0.25 s at 12 MHz); must be ≥ 2
CNT_W, 22, tick counter width; must satisfy 2^CNT_W ≥ TICK_DIV

Ports:
clk  in  1  system clock, 12 MHz
rst  in  1  asynchronous, active-low reset
a_in  in  WIDTH  operand A, switches; sampled only in LOAD
b_in  in  WIDTH  operand B, switches; sampled only in LOAD
start_pulse  in  1  one-cycle pulse from debouncer; begins an addition
step_pulse  in  1  one-cycle pulse from debouncer; advance in step mode
clear_pulse  in  1  one-cycle pulse; abort/clear to IDLE
mode  in  1  0 = auto (tick), 1 = single-step
busy  out  1  high in LOAD and ADD
done  out  1  high in DONE
sum_out  out  WIDTH+1  {carry_reg, sum_reg}; live partial value, final when done=1
bit_idx  out  clog2(WIDTH)+1  count of bits processed, 0..WIDTH
serial_bit  out  1  sum bit produced at the last advance

Behaviour:
- Reset (rst=0, async): state=IDLE; a_reg, b_reg, sum_reg, carry_reg, bit_idx, serial_bit, tick_cnt all 0; busy=0, done=0.
- States:
  - IDLE: start_pulse moves to LOAD.
  - LOAD: lasts exactly 1 cycle. Sets a_reg=a_in, b_reg=b_in, sum_reg=0, carry_reg=0, bit_idx=0, tick_cnt=0. Then moves to ADD.
  - ADD: on each advance, s=a_reg[0]^b_reg[0]^carry_reg and carry_reg=majority(a_reg[0],b_reg[0],carry_reg).
    - a_reg and b_reg shift right with 0 fill.
    - sum_reg shifts right with s entering the MSB, serial_bit=s, bit_idx+1.
    - The advance that makes bit_idx=WIDTH also transitions to DONE at the same edge.
  - DONE: holds all registers. start_pulse goes to LOAD (new operands). clear_pulse goes to IDLE.
- Advance event:
  - mode=0: tick_cnt counts in ADD and wraps at TICK_DIV-1. Advance occurs in the cycle where tick_cnt==TICK_DIV-1.
  - mode=1: advance = step_pulse. tick_cnt is held at 0 while mode=1.
  - step_pulse is ignored in auto mode.
- Auto latency: start_pulse seen at cycle 0, LOAD at cycle 1, ADD from cycle 2. Advances occur at cycles 2+k·TICK_DIV−1, k=1..WIDTH. done rises at cycle WIDTH·TICK_DIV+2.
- Priority, highest first: rst > clear_pulse > state logic.
  - clear_pulse in any state: next state IDLE; all datapath registers and bit_idx zeroed.
- start_pulse in LOAD or ADD is ignored; the current addition is not restarted.
- A mode change mid-ADD takes effect from the next cycle. Bits already processed are kept.
- Simultaneous start_pulse and clear_pulse: clear wins, ending in IDLE.
- Overflow: carry out of the MSB appears as sum_out[WIDTH]. There is no wrap and no separate flag.
- All outputs are registered or decoded from the state register only; no combinational path from inputs to outputs.

Decomposition:
- Package serial_add_pkg:
  - state encoding IDLE/LOAD/ADD/DONE (2 bits)
  - default WIDTH and TICK_DIV constants
  - bit_idx width function
- One sub-module, serial_add_tick:
  - inputs clk, rst, enable (state==ADD && mode==0), sync clear
  - output: one-cycle tick at count TICK_DIV-1
- FSM and datapath shift registers stay in serial_add_ctrl.

Test Plan:
1. WIDTH=4, TICK_DIV=4, mode=0, a=0101, b=0011, start at cycle 0 -> busy cycles 1–17; done rises at cycle 18; sum_out=01000; bit_idx=4.
2. mode=0, a=1111, b=1111 -> sum_out=11110; serial_bit sequence 0,1,1,1; carry_reg=1 after each advance.
3. mode=1, a=1001, b=0111; 3 step pulses -> bit_idx=3, busy=1, sum_out[3:1]=000, carry=1; 4th pulse -> done=1 next cycle, sum_out=10000.
4. clear_pulse at cycle 9 of test 1 -> IDLE at cycle 10, sum_out=0, busy=0, done=0; following start with a=0010, b=0001 -> sum_out=00011.
5. start_pulse during ADD (cycle 6) -> ignored, result still 01000. start in DONE with a=0001, b=0001 -> LOAD next cycle, final sum_out=00010.
6. rst low at cycle 7 (async, mid-clock) -> outputs 0 immediately. After release, start_pulse is required before any activity; no tick advances occur in IDLE.
